// File: rtl/run_sequencer_if.sv
// Start/Ack launch handshake and core-control signals between the bench side
// (master) and run_sequencer (slave).
interface run_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CYC_W = 16
);
    logic             Start;
    logic             Halt;
    logic             Ack;
    logic             CoreEn;
    logic             PcInit;
    logic [PC_W-1:0]  PcInitVal;
    logic [1:0]       ProgIdx;
    logic [CYC_W-1:0] CycleCount;
    logic             Timeout;

    // Start is a level request. Ack is a level that holds until the next Start.
    // Halt is only meaningful while CoreEn=1.
    modport master (
        output Start, Halt,
        input  Ack, CoreEn, PcInit, PcInitVal, ProgIdx, CycleCount, Timeout
    );

    modport slave (
        input  Start, Halt,
        output Ack, CoreEn, PcInit, PcInitVal, ProgIdx, CycleCount, Timeout
    );
endinterface

// File: rtl/run_sequencer.sv
// Launch sequencer: arms the PC with the current program entry, runs the core
// until Halt, then acks and steps P1->P2->P3. Optional watchdog: RUN_WATCHDOG_EN.
module run_sequencer #(
    parameter int PC_W       = 10,
    parameter int P1_ADDR    = 0,
    parameter int P2_ADDR    = 128,
    parameter int P3_ADDR    = 256,
    parameter int CYC_W      = 16,
    parameter int WDOG_LIMIT = 60000
) (
    input  logic                Clk,
    input  logic                Reset,
    run_sequencer_if.slave      bus,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    state_t           state;
    logic             ack_q;
    logic             core_en_q;
    logic             pc_init_q;
    logic [PC_W-1:0]  pc_val_q;
    logic [1:0]       idx_q;
    logic [CYC_W-1:0] cyc_q;
    logic [1:0]       next_idx;
    logic [CYC_W-1:0] cyc_inc;

    function automatic logic [PC_W-1:0] entry_addr(input logic [1:0] idx);
        case (idx)
            2'd1:    entry_addr = PC_W'(P2_ADDR);
            2'd2:    entry_addr = PC_W'(P3_ADDR);
            default: entry_addr = PC_W'(P1_ADDR);
        endcase
    endfunction

    assign next_idx = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    assign cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);

`ifdef RUN_WATCHDOG_EN
    localparam logic [CYC_W-1:0] WDOG = CYC_W'(WDOG_LIMIT);
    logic tmo_q;
    logic wdog_hit;
    assign wdog_hit    = (cyc_inc == WDOG);
    assign bus.Timeout = tmo_q;
`else
    assign bus.Timeout = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            ack_q     <= 1'b0;
            core_en_q <= 1'b0;
            pc_init_q <= 1'b0;
            pc_val_q  <= PC_W'(P1_ADDR);
            idx_q     <= 2'd0;
            cyc_q     <= '0;
`ifdef RUN_WATCHDOG_EN
            tmo_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        state     <= ARMED;
                        pc_init_q <= 1'b1;
                        ack_q     <= 1'b0;
                        core_en_q <= 1'b0;
                        pc_val_q  <= entry_addr(idx_q);
                        cyc_q     <= '0;
`ifdef RUN_WATCHDOG_EN
                        tmo_q     <= 1'b0;
`endif
                    end
                end
                ARMED: begin
                    // PC keeps loading for as long as Start is held.
                    if (!bus.Start) begin
                        state     <= RUN;
                        pc_init_q <= 1'b0;
                        core_en_q <= 1'b1;
                    end
                end
                RUN: begin
                    cyc_q <= cyc_inc;
                    if (bus.Halt) begin
                        state     <= DONE;
                        core_en_q <= 1'b0;
                        ack_q     <= 1'b1;
                        idx_q     <= next_idx;
                        pc_val_q  <= entry_addr(next_idx);
                    end
`ifdef RUN_WATCHDOG_EN
                    else if (wdog_hit) begin
                        state     <= DONE;
                        core_en_q <= 1'b0;
                        ack_q     <= 1'b1;
                        tmo_q     <= 1'b1;
                        idx_q     <= next_idx;
                        pc_val_q  <= entry_addr(next_idx);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Ack        = ack_q;
    assign bus.CoreEn     = core_en_q;
    assign bus.PcInit     = pc_init_q;
    assign bus.PcInitVal  = pc_val_q;
    assign bus.ProgIdx    = idx_q;
    assign bus.CycleCount = cyc_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed launches plus randomized launches checked
// against a per-launch transaction model (program table, hold and run lengths).
module tb_run_sequencer;
    logic       Clk;
    logic       Reset;
    logic [1:0] state_dbg;

    run_sequencer_if #(.PC_W(10), .CYC_W(16)) bus ();

    run_sequencer #(.WDOG_LIMIT(20)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         m_prog   = 0;
    int         addr_tab[3] = '{0, 128, 256};
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start held for 'hold' cycles gives exactly 'hold' ARMED cycles.
    task automatic arm(input int hold);
        logic [9:0] exp_addr;
        exp_q.push_back(10'(addr_tab[m_prog]));
        bus.Start = 1'b1;
        bus.Halt  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            check("armed_pcinit", bus.PcInit, 1);
            check("armed_coreen", bus.CoreEn, 0);
            check("armed_ack", bus.Ack, 0);
            check("armed_prog", bus.ProgIdx, m_prog);
            if (i == 0) begin
                exp_addr = exp_q.pop_front();
                check("armed_pcval", bus.PcInitVal, exp_addr);
                check("armed_cyc", bus.CycleCount, 0);
                check("armed_tmo", bus.Timeout, 0);
            end
            if (i == hold - 1) bus.Start = 1'b0;
        end
    endtask

    task automatic run_body(input int n, input bit noise, input bit halt_last);
        for (int j = 1; j <= n; j++) begin
            @(negedge Clk);
            check("run_coreen", bus.CoreEn, 1);
            check("run_pcinit", bus.PcInit, 0);
            check("run_ack", bus.Ack, 0);
            check("run_cyc", bus.CycleCount, j - 1);
            check("run_tmo", bus.Timeout, 0);
            if (j < n || !halt_last) begin
                bus.Halt  = 1'b0;
                bus.Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                bus.Halt  = 1'b1;
                bus.Start = 1'b0;
            end
        end
    endtask

    task automatic finish_check(input int n, input bit tmo);
        @(negedge Clk);
        bus.Halt  = 1'b0;
        bus.Start = 1'b0;
        m_prog = (m_prog + 1) % 3;
        check("done_ack", bus.Ack, 1);
        check("done_coreen", bus.CoreEn, 0);
        check("done_pcinit", bus.PcInit, 0);
        check("done_cyc", bus.CycleCount, n);
        check("done_prog", bus.ProgIdx, m_prog);
        check("done_pcval", bus.PcInitVal, addr_tab[m_prog]);
        check("done_tmo", bus.Timeout, tmo);
    endtask

    task automatic launch(input int hold, input int n, input bit noise);
        arm(hold);
        run_body(n, noise, 1'b1);
        finish_check(n, 1'b0);
    endtask

    task automatic halt_pulse(input bit exp_ack, input int exp_cyc);
        @(negedge Clk);
        bus.Halt = 1'b1;
        @(negedge Clk);
        bus.Halt = 1'b0;
        @(negedge Clk);
        check("idle_halt_coreen", bus.CoreEn, 0);
        check("idle_halt_pcinit", bus.PcInit, 0);
        check("idle_halt_ack", bus.Ack, exp_ack);
        check("idle_halt_prog", bus.ProgIdx, m_prog);
        check("idle_halt_cyc", bus.CycleCount, exp_cyc);
    endtask

    initial begin
        int hold;
        int len;
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Halt  = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_ack", bus.Ack, 0);
        check("rst_coreen", bus.CoreEn, 0);
        check("rst_pcinit", bus.PcInit, 0);
        check("rst_pcval", bus.PcInitVal, 0);
        check("rst_prog", bus.ProgIdx, 0);
        check("rst_cyc", bus.CycleCount, 0);
        check("rst_tmo", bus.Timeout, 0);
        Reset = 1'b0;

        halt_pulse(1'b0, 0);

        // Single-cycle Start, five RUN cycles.
        launch(1, 5, 1'b0);
        halt_pulse(1'b1, 5);

        // P2, P3 (long hold, Start noise during RUN), then wrap to P1 with Halt on first RUN cycle.
        launch(1, 3, 1'b0);
        launch(4, 6, 1'b1);
        launch(2, 1, 1'b0);

        // Reset in the middle of P2.
        arm(1);
        run_body(3, 1'b0, 1'b0);
        Reset     = 1'b1;
        bus.Start = 1'b0;
        @(negedge Clk);
        Reset  = 1'b0;
        m_prog = 0;
        check("midrst_coreen", bus.CoreEn, 0);
        check("midrst_ack", bus.Ack, 0);
        check("midrst_prog", bus.ProgIdx, 0);
        check("midrst_cyc", bus.CycleCount, 0);
        check("midrst_pcval", bus.PcInitVal, 0);
        launch(1, 2, 1'b0);

        for (int k = 0; k < 10; k++) begin
            hold = $urandom_range(1, 4);
            len  = $urandom_range(1, 12);
            launch(hold, len, 1'b1);
        end

`ifdef RUN_WATCHDOG_EN
        arm(1);
        run_body(20, 1'b0, 1'b0);
        finish_check(20, 1'b1);
        // Halt on the limit cycle wins over the watchdog.
        launch(1, 20, 1'b0);
`else
        launch(1, 30, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
